// File: rtl/rx_mac_if.sv
// MAC receive-side bus: 64-bit data beat with byte enables plus end-of-frame status pulses.
interface rx_mac_if;
  logic [63:0] rx_data;
  logic [7:0]  rx_data_valid;
  logic        rx_good_frame;
  logic        rx_bad_frame;

  modport master (
    output rx_data,
    output rx_data_valid,
    output rx_good_frame,
    output rx_bad_frame
  );

  modport slave (
    input rx_data,
    input rx_data_valid,
    input rx_good_frame,
    input rx_bad_frame
  );
endinterface

// File: rtl/rx_mac_interface.sv
// Writes MAC Rx frames into a qword ring buffer behind a one-qword byte-count header;
// good frames are committed by moving commited_wr_addr, bad/overflowing ones are rolled back.
module rx_mac_interface #(
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  rx_mac_if.slave               rx,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [63:0]           wr_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH:0]   commited_wr_addr,
  input  logic [ADDR_WIDTH:0]   commited_rd_addr,
  output logic [31:0]           good_frames,
  output logic [31:0]           dropped_frames
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  localparam logic [1:0] S_RESYNC = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_FRAME  = 2'd2;
  localparam logic [1:0] S_DROP   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         sof_q, sof_d;
  logic [31:0]           byte_count_q, byte_count_d;
  logic                  partial_q, partial_d;
  logic                  commit_pend_q, commit_pend_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [63:0]           wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic [PW-1:0]         commit_q, commit_d;
  logic [31:0]           good_q, good_d;
  logic [31:0]           dropped_q, dropped_d;

  logic                  beat_c;
  logic                  accept_c;
  logic                  legal_c;
  logic [PW-1:0]         fill_c;
  logic [3:0]            pop_c;

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(m[i]);
    return c;
  endfunction

  // Occupancy seen from the reader; the top bit set means the ring is full at wr_ptr.
  assign fill_c   = wr_ptr_q - commited_rd_addr;
  assign accept_c = ~fill_c[PW-1];
  assign beat_c   = (rx.rx_data_valid != 8'h00);
  assign legal_c  = beat_c && ((rx.rx_data_valid & (rx.rx_data_valid + 8'd1)) == 8'h00);
  assign pop_c    = popcount8(rx.rx_data_valid);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    sof_d         = sof_q;
    byte_count_d  = byte_count_q;
    partial_d     = partial_q;
    commit_pend_d = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_en_d       = 1'b0;
    commit_d      = commit_q;
    good_d        = good_q;
    dropped_d     = dropped_q;

    // Commit lands the cycle after the header write; sof_q already holds the end pointer.
    if (commit_pend_q) begin
      commit_d = sof_q;
      good_d   = good_q + 32'd1;
    end

    case (state_q)
      S_RESYNC: begin
        if (!beat_c) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (beat_c) begin
          if (accept_c && legal_c) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = wr_ptr_q[ADDR_WIDTH-1:0];
            wr_data_d    = rx.rx_data;
            wr_ptr_d     = wr_ptr_q + PW'(1);
            byte_count_d = 32'(pop_c);
            partial_d    = (rx.rx_data_valid != 8'hFF);
            state_d      = S_FRAME;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_FRAME: begin
        if (beat_c) begin
          if (accept_c && legal_c && !partial_q) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = wr_ptr_q[ADDR_WIDTH-1:0];
            wr_data_d    = rx.rx_data;
            wr_ptr_d     = wr_ptr_q + PW'(1);
            byte_count_d = byte_count_q + 32'(pop_c);
            partial_d    = (rx.rx_data_valid != 8'hFF);
          end else begin
            wr_ptr_d = sof_q + PW'(1);
            state_d  = S_DROP;
          end
        end else if (rx.rx_bad_frame) begin
          dropped_d = dropped_q + 32'd1;
          wr_ptr_d  = sof_q + PW'(1);
          state_d   = S_IDLE;
        end else if (rx.rx_good_frame) begin
          wr_en_d       = 1'b1;
          wr_addr_d     = sof_q[ADDR_WIDTH-1:0];
          wr_data_d     = {byte_count_q, 32'h0};
          commit_pend_d = 1'b1;
          sof_d         = wr_ptr_q;
          wr_ptr_d      = wr_ptr_q + PW'(1);
          state_d       = S_IDLE;
        end
      end
      S_DROP: begin
        wr_ptr_d = sof_q + PW'(1);
        if (rx.rx_good_frame || rx.rx_bad_frame) begin
          dropped_d = dropped_q + 32'd1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_RESYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RESYNC;
      wr_ptr_q      <= PW'(1);
      sof_q         <= '0;
      byte_count_q  <= '0;
      partial_q     <= 1'b0;
      commit_pend_q <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_en_q       <= 1'b0;
      commit_q      <= '0;
      good_q        <= '0;
      dropped_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      sof_q         <= sof_d;
      byte_count_q  <= byte_count_d;
      partial_q     <= partial_d;
      commit_pend_q <= commit_pend_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_en_q       <= wr_en_d;
      commit_q      <= commit_d;
      good_q        <= good_d;
      dropped_q     <= dropped_d;
    end
  end

  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign wr_en            = wr_en_q;
  assign commited_wr_addr = commit_q;
  assign good_frames      = good_q;
  assign dropped_frames   = dropped_q;

endmodule

// File: tb/tb_rx_mac_interface.sv
// Directed bench for rx_mac_interface: expected ring writes are queued as frames are driven
// and compared as the write port fires; counters and commit pointer are checked per step.
module tb_rx_mac_interface;
  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic          wr_en;
  logic [AW:0]   commited_wr_addr;
  logic [AW:0]   commited_rd_addr;
  logic [31:0]   good_frames;
  logic [31:0]   dropped_frames;

  always #5 clk = ~clk;

  rx_mac_if mac();

  rx_mac_interface #(.ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx               (mac),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_en            (wr_en),
    .commited_wr_addr (commited_wr_addr),
    .commited_rd_addr (commited_rd_addr),
    .good_frames      (good_frames),
    .dropped_frames   (dropped_frames)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    bit            hdr;
    logic [AW:0]   commit;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         got_e;
  int          total = 0;
  int          bad = 0;
  logic [AW:0] m_commit;
  logic [31:0] m_good;
  logic [31:0] m_dropped;
  bit          pend = 1'b0;
  logic [AW:0] pend_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor; a header write arms a commit check for the following cycle.
  always @(negedge clk) begin
    if (pend) begin
      chk("commit_after_hdr", 64'(commited_wr_addr), 64'(pend_val));
      pend = 1'b0;
    end
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_write: got addr %0h want no write", wr_addr);
      end else begin
        got_e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(got_e.addr));
        chk("wr_data", wr_data, got_e.data);
        if (got_e.hdr) begin
          pend     = 1'b1;
          pend_val = got_e.commit;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mac.rx_data_valid = 8'h00;
    mac.rx_good_frame = 1'b0;
    mac.rx_bad_frame  = 1'b0;
    tick();
  endtask

  task automatic send_frame(input int n, input logic [7:0] first_mask,
                            input logic [7:0] last_mask, input bit good);
    logic [AW:0]  ptr;
    logic [AW:0]  diff;
    logic [31:0]  bytes;
    logic [7:0]   m;
    logic [63:0]  d;
    bit           drop;
    bit           part;
    ptr   = m_commit + (AW+1)'(1);
    bytes = 32'd0;
    drop  = 1'b0;
    part  = 1'b0;
    for (int i = 0; i < n; i++) begin
      m    = (i == n - 1) ? last_mask : ((i == 0) ? first_mask : 8'hFF);
      d    = {$urandom, $urandom};
      diff = ptr - commited_rd_addr;
      if (!drop) begin
        if (part || diff[AW]) begin
          drop = 1'b1;
        end else begin
          exp_q.push_back(wr_t'{addr: ptr[AW-1:0], data: d, hdr: 1'b0, commit: '0});
          ptr   = ptr + (AW+1)'(1);
          bytes = bytes + 32'($countones(m));
          part  = (m != 8'hFF);
        end
      end
      mac.rx_data       = d;
      mac.rx_data_valid = m;
      tick();
    end
    idle();
    if (good && !drop) begin
      exp_q.push_back(wr_t'{addr: m_commit[AW-1:0], data: {bytes, 32'h0}, hdr: 1'b1, commit: ptr});
      m_commit = ptr;
      m_good   = m_good + 32'd1;
    end else begin
      m_dropped = m_dropped + 32'd1;
    end
    mac.rx_good_frame = good;
    mac.rx_bad_frame  = !good;
    tick();
    idle();
  endtask

  task automatic check_state(input string tag);
    idle();
    idle();
    chk({tag, "_commit"}, 64'(commited_wr_addr), 64'(m_commit));
    chk({tag, "_good"}, 64'(good_frames), 64'(m_good));
    chk({tag, "_dropped"}, 64'(dropped_frames), 64'(m_dropped));
  endtask

  initial begin
    int n;
    logic [AW:0] ptr;
    logic [63:0] d;
    reset             = 1'b1;
    mac.rx_data       = '0;
    mac.rx_data_valid = 8'h00;
    mac.rx_good_frame = 1'b0;
    mac.rx_bad_frame  = 1'b0;
    commited_rd_addr  = '0;
    m_commit          = '0;
    m_good            = '0;
    m_dropped         = '0;
    repeat (3) tick();
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_commit", 64'(commited_wr_addr), 64'd0);
    chk("rst_good", 64'(good_frames), 64'd0);
    chk("rst_dropped", 64'(dropped_frames), 64'd0);
    reset = 1'b0;
    repeat (3) idle();

    // 64-byte and 61-byte good frames
    send_frame(8, 8'hFF, 8'hFF, 1'b1);
    check_state("f64");
    chk("f64_commit_abs", 64'(commited_wr_addr), 64'd9);
    send_frame(8, 8'hFF, 8'h1F, 1'b1);
    check_state("f61");
    chk("f61_commit_abs", 64'(commited_wr_addr), 64'd18);

    // bad frame rolls back; next good frame reuses the same start slot
    send_frame(4, 8'hFF, 8'hFF, 1'b0);
    check_state("bad");
    chk("bad_commit_abs", 64'(commited_wr_addr), 64'd18);
    send_frame(3, 8'hFF, 8'hFF, 1'b1);
    check_state("reuse");
    chk("reuse_commit_abs", 64'(commited_wr_addr), 64'd22);

    // fill the ring up to slot 500 with the reader parked at 0
    while (int'(m_commit) + 64 <= 500) send_frame(63, 8'hFF, 8'hFF, 1'b1);
    n = 500 - int'(m_commit) - 1;
    if (n > 0) send_frame(n, 8'hFF, 8'hFF, 1'b1);
    check_state("fill");
    chk("fill_commit_abs", 64'(commited_wr_addr), 64'd500);

    // overflow at wr_ptr 512, then a wrapping frame once the reader moves on
    send_frame(16, 8'hFF, 8'hFF, 1'b1);
    check_state("ovf");
    chk("ovf_commit_abs", 64'(commited_wr_addr), 64'd500);
    commited_rd_addr = (AW+1)'(100);
    send_frame(16, 8'hFF, 8'hFF, 1'b1);
    check_state("wrap");
    chk("wrap_commit_abs", 64'(commited_wr_addr), 64'd517);

    // reset lands on beat 4; the tail and its good pulse must be swallowed
    ptr = m_commit + (AW+1)'(1);
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      if (i < 3) exp_q.push_back(wr_t'{addr: ptr[AW-1:0], data: d, hdr: 1'b0, commit: '0});
      ptr = ptr + (AW+1)'(1);
      if (i == 3) reset = 1'b1;
      if (i == 5) reset = 1'b0;
      mac.rx_data       = d;
      mac.rx_data_valid = 8'hFF;
      tick();
    end
    commited_rd_addr = '0;
    m_commit  = '0;
    m_good    = '0;
    m_dropped = '0;
    idle();
    mac.rx_good_frame = 1'b1;
    tick();
    idle();
    check_state("rst_mid");
    chk("rst_mid_commit_abs", 64'(commited_wr_addr), 64'd0);
    send_frame(4, 8'hFF, 8'hFF, 1'b1);
    check_state("post_rst");
    chk("post_rst_commit_abs", 64'(commited_wr_addr), 64'd5);

    // a full beat after a partial beat drops the frame
    send_frame(2, 8'h0F, 8'hFF, 1'b1);
    check_state("partial");
    chk("partial_dropped_abs", 64'(dropped_frames), 64'd1);
    chk("partial_commit_abs", 64'(commited_wr_addr), 64'd5);

    repeat (4) idle();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
